// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- RV32I load/store unit
//
// Accepts one memory operation at a time from the execute stage. It checks
// that the access is aligned and legal, and formats store data and byte
// enables for a word-aligned data port. It then runs the transfer on a
// req/gnt/rvalid bus and returns extended load data to writeback.
// Illegal or misaligned accesses never reach memory. They complete with
// resp_err one cycle after acceptance.
//
// Optional feature macro: LSU_RVALID_BYPASS_EN
//   Defined   : the load response (resp_valid/resp_we/resp_rdata) is driven
//               combinationally in the cycle mem_rvalid arrives, and the FSM
//               returns to IDLE directly from WAIT.
//   Undefined : the load response is registered one cycle after mem_rvalid.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_*               operation from execute; req_ready high only in IDLE
//   flush               pipeline kill, abandons the in-flight operation
//   mem_req/gnt/we/addr/be/wdata/rvalid/rdata
//                       data-memory bus; mem_req held until mem_gnt
//   resp_valid/we/rd/rdata/err
//                       one-cycle completion towards writeback
//   busy                FSM not in IDLE
// ---------------------------------------------------------------------------
module lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_is_store,
  input  logic [2:0]                req_funct3,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd,
  input  logic                      flush,
  output logic                      mem_req,
  input  logic                      mem_gnt,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [3:0]                mem_be,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      resp_valid,
  output logic                      resp_we,
  output logic [REG_ADDR_WIDTH-1:0] resp_rd,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_err,
  output logic                      busy
);

`ifdef LSU_RVALID_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  // Size/alignment legality. Unsigned variants exist only for loads.
  function automatic logic legal_f(input logic st, input logic [2:0] f3,
                                   input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~off[0];
      3'b010:  ok = (off == 2'b00);
      3'b100:  ok = ~st;
      3'b101:  ok = ~st & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte enables: stores select their lanes, loads always read the full word.
  function automatic logic [3:0] be_f(input logic st, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    if (st) begin
      case (f3[1:0])
        2'b00:   be = 4'b0001 << off;
        2'b01:   be = 4'b0011 << off;
        default: be = 4'b1111;
      endcase
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  // Replicate the store datum across lanes so memory can pick it up from
  // whichever lane the byte enables select.
  function automatic logic [DATA_WIDTH-1:0] wdata_f(input logic st,
                                                    input logic [2:0] f3,
                                                    input logic [DATA_WIDTH-1:0] wd);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    if (st) begin
      case (f3[1:0])
        2'b00:   d = {4{wd[7:0]}};
        2'b01:   d = {2{wd[15:0]}};
        default: d = wd;
      endcase
    end else begin
      d = '0;
    end
    return d;
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  function automatic logic [DATA_WIDTH-1:0] extract_f(input logic [2:0] f3,
                                                      input logic [1:0] off,
                                                      input logic [DATA_WIDTH-1:0] rd);
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] d;
    sh = rd >> {off, 3'b000};
    case (f3)
      3'b000:  d = {{24{sh[7]}}, sh[7:0]};
      3'b001:  d = {{16{sh[15]}}, sh[15:0]};
      3'b010:  d = sh;
      3'b100:  d = {24'h000000, sh[7:0]};
      3'b101:  d = {16'h0000, sh[15:0]};
      default: d = '0;
    endcase
    return d;
  endfunction

  state_e                      state_q, state_d;
  logic [1:0]                  off_q;
  logic [2:0]                  funct3_q;
  logic                        is_store_q;
  logic [REG_ADDR_WIDTH-1:0]   rd_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic                        we_q;
  logic [3:0]                  be_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  logic                        req_ready_q, busy_q, mem_req_q;
  logic                        resp_valid_q, resp_we_q, resp_err_q;
  logic [DATA_WIDTH-1:0]       resp_rdata_q;

  logic                        take_rvalid_s;
  logic                        bypass_s;
  logic [DATA_WIDTH-1:0]       ext_s;

  // Read data is consumed only in WAIT and only if the op is not being killed.
  assign take_rvalid_s = (state_q == S_WAIT) && mem_rvalid && !flush;
  assign bypass_s      = BYPASS && take_rvalid_s;
  assign ext_s         = extract_f(funct3_q, off_q, mem_rdata);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = legal_f(req_is_store, req_funct3, req_addr[1:0]) ? S_REQ : S_ERR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          // A granted store has already written memory; flush only drops the response.
          if (is_store_q) state_d = flush ? S_IDLE : S_RESP;
          else            state_d = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        // Flush with rvalid in the same cycle: data is gone, nothing left to drain.
        if (mem_rvalid) begin
          state_d = (flush || BYPASS) ? S_IDLE : S_RESP;
        end else if (flush) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid) state_d = S_IDLE;
        else            state_d = S_DRAIN;
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched request fields, and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      off_q        <= 2'b00;
      funct3_q     <= 3'b000;
      is_store_q   <= 1'b0;
      rd_q         <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= 4'b0000;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid) begin
        off_q      <= req_addr[1:0];
        funct3_q   <= req_funct3;
        is_store_q <= req_is_store;
        rd_q       <= req_rd;
        addr_q     <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        we_q       <= req_is_store;
        be_q       <= be_f(req_is_store, req_funct3, req_addr[1:0]);
        wdata_q    <= wdata_f(req_is_store, req_funct3, req_wdata);
      end
      req_ready_q  <= (state_d == S_IDLE);
      busy_q       <= (state_d != S_IDLE);
      mem_req_q    <= (state_d == S_REQ);
      resp_valid_q <= (state_d == S_RESP) || (state_d == S_ERR);
      resp_err_q   <= (state_d == S_ERR);
      resp_we_q    <= (state_d == S_RESP) && !is_store_q && (rd_q != '0);
      resp_rdata_q <= ((state_d == S_RESP) && take_rvalid_s) ? ext_s : '0;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_be     = be_q;
  assign mem_wdata  = wdata_q;
  assign resp_rd    = rd_q;
  assign resp_err   = resp_err_q;
  assign resp_valid = resp_valid_q | bypass_s;
  assign resp_we    = resp_we_q | (bypass_s && (rd_q != '0));
  assign resp_rdata = bypass_s ? ext_s : resp_rdata_q;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu
//
// A transaction-level model computes, for each operation, the expected
// legality, byte enables, replicated store data and extended load data with
// plain arithmetic. The driver walks the operation cycle by cycle and
// publishes what every output must be in that cycle. A single compare
// process checks the DUT against those expectations on each falling edge.
// Directed operations from the test plan add literal checks.
// ---------------------------------------------------------------------------
module tb_lsu;

`ifdef LSU_RVALID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        flush = 1'b0;
  logic        mem_req, mem_gnt = 1'b0, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        resp_valid, resp_we, resp_err, busy;
  logic [4:0]  resp_rd;
  logic [31:0] resp_rdata;

  lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .flush(flush),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int resp_cyc = -100;
  bit chk_en = 1'b0;

  // expectations for the current cycle
  bit          exp_ready, exp_busy, exp_mreq, exp_rv;
  bit          exp_err, exp_rwe, exp_we;
  logic [4:0]  exp_rd;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  // last values observed on the DUT, for literal checks
  logic [31:0] last_addr = 32'd0, last_wdata = 32'd0, last_rdata = 32'd0;
  logic [3:0]  last_be = 4'd0;
  logic        last_we = 1'b0, last_err = 1'b0, last_rwe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Single compare process against the model expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("mem_req", {31'd0, mem_req}, {31'd0, exp_mreq});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_rv});
      if (exp_mreq) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (exp_rv) begin
        chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
        chk("resp_we", {31'd0, resp_we}, {31'd0, exp_rwe});
        chk("resp_rd", {27'd0, resp_rd}, {27'd0, exp_rd});
        chk("resp_rdata", resp_rdata, exp_rdata);
      end
    end
    if (resp_valid === 1'b1) begin
      resp_cyc   = cyc;
      last_rdata = resp_rdata;
      last_err   = resp_err;
      last_rwe   = resp_we;
    end
    if (mem_req === 1'b1) begin
      last_addr  = mem_addr;
      last_be    = mem_be;
      last_we    = mem_we;
      last_wdata = mem_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit r, input bit b, input bit m, input bit v);
    exp_ready = r; exp_busy = b; exp_mreq = m; exp_rv = v;
  endtask

  // Request-side inputs are don't-care while busy; scramble them.
  task automatic garble();
    req_valid    = 1'($urandom % 2);
    req_is_store = 1'($urandom % 2);
    req_funct3   = 3'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_rd       = 5'($urandom);
    mem_rdata    = $urandom;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  // Reference for load extraction: pick the addressed lane arithmetically.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] rdata);
    logic [31:0] v, b, h;
    v = rdata >> (8 * off);
    b = v % 32'd256;
    h = v % 32'd65536;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd2:    return v;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  // Drain: wait n cycles, then rvalid arrives and is discarded.
  task automatic drain(input int n);
    for (int k = 0; k <= n; k++) begin
      garble();
      flush = 1'b0;
      mem_rvalid = (k == n);
      set_exp(1'b0, 1'b1, 1'b0, 1'b0);
      step();
    end
    mem_rvalid = 1'b0;
  endtask

  // fm: 0 none, 1 flush in REQ before grant, 2 flush with grant,
  //     3 flush in WAIT before rvalid, 4 flush in the response cycle.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] rdata, input int gw, input int rw, input int fm);
    int off, sz;
    bit legal;
    off   = int'(addr % 32'd4);
    sz    = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
    legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7) && !(st && f3 >= 3'd4)
            && (off % sz == 0);
    exp_addr  = addr & 32'hFFFF_FFFC;
    exp_we    = st;
    exp_be    = st ? 4'(((1 << sz) - 1) << off) : 4'hF;
    exp_wdata = (sz == 1) ? (wd % 32'd256) * 32'h0101_0101 :
                (sz == 2) ? (wd % 32'd65536) * 32'h0001_0001 : wd;
    exp_rd    = rd;
    exp_err   = !legal;
    exp_rwe   = legal && !st && (rd != 5'd0);
    exp_rdata = (legal && !st) ? model_load(f3, off, rdata) : 32'd0;

    // accept cycle
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr;
    req_wdata = wd; req_rd = rd; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    acc_cyc = cyc;
    step();

    if (!legal) begin
      garble();
      flush = (fm == 4);
      set_exp(1'b0, 1'b1, 1'b0, 1'b1);
      step();
      flush = 1'b0;
      return;
    end

    for (int i = 0; i <= gw; i++) begin
      garble();
      flush = 1'b0;
      mem_gnt = (i == gw);
      set_exp(1'b0, 1'b1, 1'b1, 1'b0);
      if (fm == 1 && i == 0) begin
        mem_gnt = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        return;
      end
      if (fm == 2 && i == gw) flush = 1'b1;
      step();
    end
    mem_gnt = 1'b0;
    flush = 1'b0;

    if (st) begin
      if (fm == 2) return;
      garble();
      flush = (fm == 4);
      set_exp(1'b0, 1'b1, 1'b0, 1'b1);
      step();
      flush = 1'b0;
      return;
    end

    if (fm == 2) begin
      drain(rw);
      return;
    end

    for (int j = 0; j <= rw; j++) begin
      garble();
      flush = 1'b0;
      mem_rvalid = 1'b0;
      set_exp(1'b0, 1'b1, 1'b0, 1'b0);
      if (fm == 3 && j == 0) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain(rw - 1);
        return;
      end
      if (j == rw) begin
        mem_rvalid = 1'b1;
        mem_rdata = rdata;
        if (BYP) set_exp(1'b0, 1'b1, 1'b0, 1'b1);
      end
      step();
    end
    mem_rvalid = 1'b0;
    if (!BYP) begin
      garble();
      flush = (fm == 4);
      set_exp(1'b0, 1'b1, 1'b0, 1'b1);
      step();
      flush = 1'b0;
    end
  endtask

  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    int gw, rw, fm, gaps;

    // reset values
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    idle_cycle();

    // SW
    do_op(1'b1, 3'd2, 32'h0000_1004, 32'hDEAD_BEEF, 5'd3, 32'd0, 0, 0, 0);
    chk("sw_addr", last_addr, 32'h0000_1004);
    chk("sw_be", {28'd0, last_be}, 32'hF);
    chk("sw_we", {31'd0, last_we}, 32'd1);
    chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    chk("sw_latency", resp_cyc - acc_cyc, 32'd2);
    chk("sw_resp_we", {31'd0, last_rwe}, 32'd0);
    // SB
    do_op(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 5'd3, 32'd0, 0, 0, 0);
    chk("sb_be", {28'd0, last_be}, 32'h8);
    chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);
    // LB / LBU / LHU
    do_op(1'b0, 3'd0, 32'h0000_2002, 32'd0, 5'd7, 32'h0080_0000, 0, 2, 0);
    chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
    chk("lb_latency", resp_cyc - acc_cyc, BYP ? 32'd4 : 32'd5);
    do_op(1'b0, 3'd4, 32'h0000_2002, 32'd0, 5'd7, 32'h0080_0000, 0, 2, 0);
    chk("lbu_rdata", last_rdata, 32'h0000_0080);
    do_op(1'b0, 3'd5, 32'h0000_2002, 32'd0, 5'd7, 32'h8001_0000, 1, 0, 0);
    chk("lhu_rdata", last_rdata, 32'h0000_8001);
    // misaligned
    do_op(1'b0, 3'd2, 32'h0000_3001, 32'd0, 5'd9, 32'd0, 0, 0, 0);
    chk("lw_mis_err", {31'd0, last_err}, 32'd1);
    chk("lw_mis_latency", resp_cyc - acc_cyc, 32'd1);
    chk("lw_mis_rdata", last_rdata, 32'd0);
    do_op(1'b1, 3'd1, 32'h0000_3003, 32'h1234_5678, 5'd9, 32'd0, 0, 0, 0);
    chk("sh_mis_err", {31'd0, last_err}, 32'd1);
    // flush in WAIT, then a normal LW
    do_op(1'b0, 3'd2, 32'h0000_4000, 32'd0, 5'd5, 32'h1111_2222, 0, 3, 3);
    do_op(1'b0, 3'd2, 32'h0000_4008, 32'd0, 5'd5, 32'hCAFE_F00D, 0, 1, 0);
    chk("lw_after_flush", last_rdata, 32'hCAFE_F00D);

    // reset while in REQ
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h0000_5000; req_wdata = 32'h0; req_rd = 5'd1;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    req_valid = 1'b0;
    chk_en = 1'b0;
    #1;
    chk("req_before_rst", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_in_req_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_in_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_in_req_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    idle_cycle();

    // randomized operations
    for (int n = 0; n < 400; n++) begin
      st   = 1'($urandom % 2);
      f3   = 3'($urandom);
      addr = $urandom;
      if ($urandom % 2 == 0) addr = addr & 32'hFFFF_FFFC;
      gw   = int'($urandom % 4);
      rw   = int'($urandom % 4);
      fm   = int'($urandom % 9);
      if (fm > 4) fm = 0;
      if (fm == 1 && gw == 0) gw = 1;
      if (fm == 3 && st) fm = 0;
      if (fm == 3 && rw == 0) rw = 1;
      if (fm == 4 && BYP && !st) fm = 0;
      do_op(st, f3, addr, $urandom, 5'($urandom), $urandom, gw, rw, fm);
      gaps = int'($urandom % 3);
      for (int g = 0; g < gaps; g++) idle_cycle();
    end
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
